// File: rtl/arb_seq_if.sv
// Handshake and bus bundle between arb_seq, its priority source, the
// external 64-square arbiter and the move-ordering consumer.
//
// The slave modport is the sequencer's view. The master modport is the
// view of everything around it: the loader, the arbiter and the consumer.
interface arb_seq_if;

    // Load side: a priority vector plus a one-cycle capture strobe.
    logic         load;
    logic [191:0] prio_in;

    // Arbiter side: the registered vector goes out, and {empty, square}
    // comes back combinationally.
    logic [191:0] arb_prio;
    logic [6:0]   arb_result;

    // Consumer side: a valid/ready stream of emitted squares.
    logic         sq_valid;
    logic         sq_ready;
    logic [5:0]   sq_out;
    logic [2:0]   sq_prio;

    // Status outputs.
    logic         busy;
    logic         done;
    logic [6:0]   count;

    modport slave (
        input  load,
        input  prio_in,
        input  arb_result,
        input  sq_ready,
        output arb_prio,
        output sq_valid,
        output sq_out,
        output sq_prio,
        output busy,
        output done,
        output count
    );

    modport master (
        output load,
        output prio_in,
        output arb_result,
        output sq_ready,
        input  arb_prio,
        input  sq_valid,
        input  sq_out,
        input  sq_prio,
        input  busy,
        input  done,
        input  count
    );

endinterface

// File: rtl/arb_seq.sv
// Sequencing front end for the 64-square priority arbiter.
//
// The block holds a 64 x 3-bit priority vector and drives it to the
// external arbiter. Each round it reads back the winning square, offers
// that square on a valid/ready stream, and zeroes the square's priority
// once the consumer accepts it. The next round then picks the next-best
// square. A sequence ends when the arbiter reports empty or when
// MAX_EMIT squares have gone out.
module arb_seq #(
    parameter int MAX_EMIT = 64
) (
    input  logic     clk,
    input  logic     rst,
    arb_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        PRESENT,
        DONE
    } state_t;

    state_t       state_q;
    logic [191:0] arbPrio_q;
    logic [5:0]   sqOut_q;
    logic [2:0]   sqPrio_q;
    logic         sqValid_q;
    logic         busy_q;
    logic         done_q;
    logic [6:0]   count_q;

    logic         arbEmpty;
    logic [5:0]   winSq;
    logic [8:0]   winShift;
    logic [191:0] winShifted;
    logic [2:0]   winPrio_d;
    logic [8:0]   clrShift;
    logic [191:0] clrMask;
    logic [191:0] arbPrioCleared_d;
    logic         limitHit;
    logic [6:0]   countInc_d;

    // Decode the arbiter result. Also look up the winner's priority field
    // in the vector that the arbiter is currently seeing.
    always_comb begin
        arbEmpty   = bus.arb_result[6];
        winSq      = bus.arb_result[5:0];
        winShift   = {3'b000, winSq} * 9'd3;
        winShifted = arbPrio_q >> winShift;
        winPrio_d  = winShifted[2:0];
    end

    // Work out the vector after the presented square's field is cleared.
    // Every other field passes through untouched.
    always_comb begin
        clrShift         = {3'b000, sqOut_q} * 9'd3;
        clrMask          = {189'd0, 3'b111} << clrShift;
        arbPrioCleared_d = arbPrio_q & ~clrMask;
    end

    // Emit-limit detection and a saturating count increment.
    always_comb begin
        limitHit   = (count_q == 7'(MAX_EMIT));
        countInc_d = limitHit ? count_q : count_q + 7'd1;
    end

    // Main sequencer FSM. All outputs are registered here. A load in any
    // state restarts the sequence and wins over a same-cycle handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            arbPrio_q <= '0;
            sqOut_q   <= '0;
            sqPrio_q  <= '0;
            sqValid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.load) begin
                arbPrio_q <= bus.prio_in;
                count_q   <= '0;
                sqValid_q <= 1'b0;
                busy_q    <= 1'b1;
                state_q   <= EVAL;
            end else begin
                case (state_q)
                    IDLE: begin
                        busy_q <= 1'b0;
                    end
                    EVAL: begin
                        if (arbEmpty || limitHit) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            sqOut_q   <= winSq;
                            sqPrio_q  <= winPrio_d;
                            sqValid_q <= 1'b1;
                            state_q   <= PRESENT;
                        end
                    end
                    PRESENT: begin
                        if (bus.sq_ready) begin
                            arbPrio_q <= arbPrioCleared_d;
                            count_q   <= countInc_d;
                            sqValid_q <= 1'b0;
                            state_q   <= EVAL;
                        end
                    end
                    DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    // Drive the registered state onto the interface.
    always_comb begin
        bus.arb_prio = arbPrio_q;
        bus.sq_valid = sqValid_q;
        bus.sq_out   = sqOut_q;
        bus.sq_prio  = sqPrio_q;
        bus.busy     = busy_q;
        bus.done     = done_q;
        bus.count    = count_q;
    end

endmodule

// File: tb/tb_arb_seq.sv
// Testbench for arb_seq.
//
// Two sequencers run side by side. One uses the default emit limit and
// the other uses MAX_EMIT = 4. Each is served by a behavioural arbiter.
// A reference model holds each sequencer's expected emission order, built
// by ranking the candidates on (priority descending, index ascending).
module tb_arb_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    int   emitLog0[$];
    int   emitLog1[$];

    arb_seq_if bus[2] ();

    always #5 clk = ~clk;

    // Compare one observed value against its expected value and tally the result.
    task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Return a copy of v with square sq set to priority p.
    function automatic logic [191:0] withSq(input logic [191:0] v, input int sq, input int p);
        logic [191:0] r;
        r = v;
        r[sq*3 +: 3] = 3'(p);
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gDut
        localparam int MAXE = (g == 0) ? 64 : 4;

        logic [2:0]   best;
        logic [5:0]   bestSq;
        logic [191:0] expPrio  = '0;
        int           expCount = 0;
        int           expQ[$];
        int           head;

        arb_seq #(.MAX_EMIT(MAXE)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus[g])
        );

        // Behavioural arbiter: highest priority wins, the lowest index wins a
        // tie, and an all-zero vector reports empty.
        always_comb begin
            best   = 3'd0;
            bestSq = 6'd0;
            for (int i = 0; i < 64; i++) begin
                if (bus[g].arb_prio[i*3 +: 3] > best) begin
                    best   = bus[g].arb_prio[i*3 +: 3];
                    bestSq = 6'(i);
                end
            end
            bus[g].arb_result = {(best == 3'd0), bestSq};
        end

        // Every cycle, check the outputs against the model, then advance the
        // model by whatever the upcoming clock edge will commit.
        always @(negedge clk) begin
            if (rst) begin
                checkOutput("reset sq_valid", bus[g].sq_valid, 0);
                checkOutput("reset busy", bus[g].busy, 0);
                checkOutput("reset done", bus[g].done, 0);
                checkOutput("reset count", bus[g].count, 0);
                checkOutput("reset arb_prio", bus[g].arb_prio, 0);
                expPrio  = '0;
                expCount = 0;
                expQ.delete();
            end else begin
                checkOutput("arb_prio track", bus[g].arb_prio, expPrio);
                checkOutput("count track", bus[g].count, 192'(expCount));
                if (bus[g].sq_valid) begin
                    checkOutput("emit expected", (expQ.size() > 0) ? 1 : 0, 1);
                    if (expQ.size() > 0) begin
                        checkOutput("emit square", bus[g].sq_out, 192'(expQ[0]));
                        checkOutput("emit prio", bus[g].sq_prio, expPrio[expQ[0]*3 +: 3]);
                    end
                end
                if (bus[g].done) begin
                    checkOutput("done only at end", (expQ.size() == 0) ? 1 : 0, 1);
                end
                if (bus[g].load) begin
                    expPrio  = bus[g].prio_in;
                    expCount = 0;
                    expQ.delete();
                    for (int p = 7; p >= 1; p--) begin
                        for (int i = 0; i < 64; i++) begin
                            if (expPrio[i*3 +: 3] == 3'(p) && expQ.size() < MAXE) begin
                                expQ.push_back(i);
                            end
                        end
                    end
                end else if (bus[g].sq_valid && bus[g].sq_ready && expQ.size() > 0) begin
                    head = expQ.pop_front();
                    expPrio[head*3 +: 3] = 3'd0;
                    expCount++;
                    if (g == 0) emitLog0.push_back(head);
                    else        emitLog1.push_back(head);
                end
            end
        end
    end

    // Hold load high for one clock edge; call this just after a rising edge.
    task automatic applyStimulus(input int sel, input logic [191:0] vec, input logic ready);
        if (sel == 0) begin
            bus[0].prio_in  = vec;
            bus[0].sq_ready = ready;
            bus[0].load     = 1'b1;
        end else begin
            bus[1].prio_in  = vec;
            bus[1].sq_ready = ready;
            bus[1].load     = 1'b1;
        end
        @(posedge clk);
        #1;
        bus[0].load = 1'b0;
        bus[1].load = 1'b0;
    endtask

    // Count cycles after the load edge until done is seen, within a limit.
    task automatic waitDone(input int sel, input int limit, output int cycles);
        int seen;
        seen   = 0;
        cycles = 0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if ((sel == 0) ? bus[0].done : bus[1].done) begin
                cycles = k;
                seen   = 1;
                break;
            end
        end
        checkOutput("done within budget", seen, 1);
    endtask

    // Wait, within a limit, for sq_valid on DUT 0.
    task automatic waitValid(input int limit);
        int seen;
        seen = 0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (bus[0].sq_valid) begin
                seen = 1;
                break;
            end
        end
        checkOutput("valid within budget", seen, 1);
    endtask

    logic [191:0] vecA;
    logic [191:0] vec20;
    logic [191:0] ones;
    int           cyc;

    initial begin
        vecA  = withSq(withSq(withSq('0, 10, 5), 3, 7), 40, 5);
        vec20 = withSq('0, 20, 2);
        ones  = '0;
        for (int i = 0; i < 64; i++) ones = withSq(ones, i, 1);
        for (int s = 0; s < 2; s++) begin
            if (s == 0) begin
                bus[0].load = 1'b0; bus[0].prio_in = '0; bus[0].sq_ready = 1'b0;
            end else begin
                bus[1].load = 1'b0; bus[1].prio_in = '0; bus[1].sq_ready = 1'b0;
            end
        end
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset.
        @(negedge clk);
        checkOutput("idle busy", bus[0].busy, 0);
        checkOutput("idle sq_valid", bus[0].sq_valid, 0);
        checkOutput("idle count", bus[1].count, 0);

        // All-zero vector: done two cycles after the load edge, no emission.
        @(posedge clk); #1;
        applyStimulus(0, '0, 1'b1);
        waitDone(0, 20, cyc);
        checkOutput("zero done latency", cyc, 2);
        checkOutput("zero count", bus[0].count, 0);
        checkOutput("zero busy in done", bus[0].busy, 1);
        @(negedge clk);
        checkOutput("zero done one cycle", bus[0].done, 0);
        checkOutput("zero busy after", bus[0].busy, 0);

        // Three candidates with ready tied high: (3,7), (10,5), (40,5).
        emitLog0.delete();
        @(posedge clk); #1;
        applyStimulus(0, vecA, 1'b1);
        waitDone(0, 40, cyc);
        checkOutput("three done latency", cyc, 8);
        checkOutput("three count", bus[0].count, 3);
        checkOutput("three emitted", emitLog0.size(), 3);
        if (emitLog0.size() == 3) begin
            checkOutput("three first", emitLog0[0], 3);
            checkOutput("three second", emitLog0[1], 10);
            checkOutput("three third", emitLog0[2], 40);
        end
        checkOutput("three residual", bus[0].arb_prio, 0);
        @(negedge clk);
        checkOutput("three busy after", bus[0].busy, 0);

        // Back-pressure: the presented square holds steady while ready is low.
        @(posedge clk); #1;
        applyStimulus(0, vecA, 1'b0);
        waitValid(10);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("stall sq_valid", bus[0].sq_valid, 1);
            checkOutput("stall sq_out", bus[0].sq_out, 3);
            checkOutput("stall sq_prio", bus[0].sq_prio, 7);
            checkOutput("stall arb_prio", bus[0].arb_prio, vecA);
        end
        @(posedge clk); #1 bus[0].sq_ready = 1'b1;
        @(posedge clk); #1 bus[0].sq_ready = 1'b0;
        @(negedge clk);
        checkOutput("stall cleared", bus[0].arb_prio, withSq(vecA, 3, 0));
        checkOutput("stall count", bus[0].count, 1);
        checkOutput("stall valid drop", bus[0].sq_valid, 0);
        @(posedge clk); #1 bus[0].sq_ready = 1'b1;
        waitDone(0, 40, cyc);
        checkOutput("stall final count", bus[0].count, 3);

        // Emit limit of 4 on a vector where every square is 1.
        emitLog1.delete();
        @(posedge clk); #1;
        applyStimulus(1, ones, 1'b1);
        waitDone(1, 60, cyc);
        checkOutput("limit count", bus[1].count, 4);
        checkOutput("limit emitted", emitLog1.size(), 4);
        if (emitLog1.size() == 4) begin
            for (int i = 0; i < 4; i++) checkOutput("limit order", emitLog1[i], i);
        end
        checkOutput("limit residual", bus[1].arb_prio, ones & ~192'hFFF);

        // Abort: a load during PRESENT with ready high in the same cycle.
        @(posedge clk); #1;
        applyStimulus(0, vecA, 1'b0);
        waitValid(10);
        @(posedge clk); #1;
        bus[0].prio_in  = vec20;
        bus[0].load     = 1'b1;
        bus[0].sq_ready = 1'b1;
        @(posedge clk); #1;
        bus[0].load     = 1'b0;
        bus[0].sq_ready = 1'b0;
        @(negedge clk);
        checkOutput("abort sq_valid", bus[0].sq_valid, 0);
        checkOutput("abort count", bus[0].count, 0);
        checkOutput("abort arb_prio", bus[0].arb_prio, vec20);
        checkOutput("abort no done", bus[0].done, 0);
        checkOutput("abort busy", bus[0].busy, 1);
        waitValid(10);
        checkOutput("abort sq_out", bus[0].sq_out, 20);
        checkOutput("abort sq_prio", bus[0].sq_prio, 2);
        checkOutput("abort count pre", bus[0].count, 0);
        @(posedge clk); #1 bus[0].sq_ready = 1'b1;
        waitDone(0, 20, cyc);
        checkOutput("abort final count", bus[0].count, 1);

        // Asynchronous reset while a square is presented.
        @(posedge clk); #1;
        applyStimulus(0, vecA, 1'b0);
        waitValid(10);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        checkOutput("async sq_valid", bus[0].sq_valid, 0);
        checkOutput("async busy", bus[0].busy, 0);
        checkOutput("async count", bus[0].count, 0);
        checkOutput("async arb_prio", bus[0].arb_prio, 0);
        checkOutput("async sq_out", bus[0].sq_out, 0);
        checkOutput("async sq_prio", bus[0].sq_prio, 0);
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("post reset done", bus[0].done, 0);
            checkOutput("post reset busy", bus[0].busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
